// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants for the writeback stage and register file.
// Holds the MemtoReg source encodings, register index constants and the reset-value helper.
package wb_regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic [1:0] {
        MEMTOREG_ALU  = 2'b00,
        MEMTOREG_MEM  = 2'b01,
        MEMTOREG_LINK = 2'b10
    } memtoreg_e;

    localparam logic [IDX_W-1:0] REG_ZERO = 5'd0;
    localparam logic [IDX_W-1:0] REG_SP   = 5'd29;

    // Every register clears to zero except $sp, which starts at the top of the stack.
    function automatic logic [DATA_W-1:0] reset_value(
        input logic [IDX_W-1:0]  idx,
        input logic [DATA_W-1:0] sp_init
    );
        return (idx == REG_SP) ? sp_init : '0;
    endfunction

endpackage

// File: rtl/wb_select.sv
// Writeback source multiplexer: picks ALU result, load data or link address.
// Unknown codes fall back to the ALU result so a stray encoding never writes garbage.
module wb_select
    import wb_regfile_pkg::*;
#(
    parameter logic [1:0] LINK_ENC = 2'b10
) (
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [1:0]        mem_to_reg,
    output logic [DATA_W-1:0] wb_data
);

    always_comb begin
        wb_data = alu_out;
        if (mem_to_reg == MEMTOREG_ALU) begin
            wb_data = alu_out;
        end else if (mem_to_reg == MEMTOREG_MEM) begin
            wb_data = mem_data;
        end else if (mem_to_reg == LINK_ENC) begin
            wb_data = pc_plus4;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// 32x32 register file with combinational read, same-cycle write bypass and a
// retired-write counter; writeback source selection lives in wb_select.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter logic [31:0] SP_INIT  = 32'h0000_03FC,
    parameter logic [1:0]  LINK_ENC = 2'b10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IMemData,
    input  logic [31:0] IALUOut,
    input  logic [31:0] IPCPlus4,
    input  logic [4:0]  IWriteReg,
    input  logic        ICRegWrite,
    input  logic [1:0]  ICMemtoReg,
    input  logic [4:0]  IReadReg1,
    input  logic [4:0]  IReadReg2,
    output logic [31:0] OReadData1,
    output logic [31:0] OReadData2,
    output logic [31:0] OWBData,
    output logic        OWBValid,
    output logic [31:0] OWriteCount
);

    logic [DATA_W-1:0] regs_reg [NUM_REGS];
    logic [DATA_W-1:0] write_count_reg;
    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;

    logic [IDX_W-1:0]  rd_idx  [2];
    logic [DATA_W-1:0] rd_data [2];

    wb_select #(
        .LINK_ENC (LINK_ENC)
    ) u_wb_select (
        .mem_data   (IMemData),
        .alu_out    (IALUOut),
        .pc_plus4   (IPCPlus4),
        .mem_to_reg (ICMemtoReg),
        .wb_data    (wb_data)
    );

    // Gating with reset also turns the bypass off while reset is held.
    assign wb_valid = ICRegWrite && (IWriteReg != REG_ZERO) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= reset_value(i[IDX_W-1:0], SP_INIT);
            end
            write_count_reg <= '0;
        end else if (wb_valid) begin
            regs_reg[IWriteReg] <= wb_data;
            write_count_reg     <= write_count_reg + 32'd1;
        end
    end

    assign rd_idx[0] = IReadReg1;
    assign rd_idx[1] = IReadReg2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            assign rd_data[gi] = (rd_idx[gi] == REG_ZERO)                 ? '0      :
                                 (wb_valid && (rd_idx[gi] == IWriteReg)) ? wb_data :
                                                                           regs_reg[rd_idx[gi]];
        end
    endgenerate

    assign OReadData1  = rd_data[0];
    assign OReadData2  = rd_data[1];
    assign OWBData     = wb_data;
    assign OWBValid    = wb_valid;
    assign OWriteCount = write_count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile: reset, writeback select, bypass, $zero,
// link, reset priority, resume after reset and counter wrap.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] IMemData;
    logic [31:0] IALUOut;
    logic [31:0] IPCPlus4;
    logic [4:0]  IWriteReg;
    logic        ICRegWrite;
    logic [1:0]  ICMemtoReg;
    logic [4:0]  IReadReg1;
    logic [4:0]  IReadReg2;
    logic [31:0] OReadData1;
    logic [31:0] OReadData2;
    logic [31:0] OWBData;
    logic        OWBValid;
    logic [31:0] OWriteCount;

    int compared_cnt;
    int mismatch_cnt;

    wb_regfile dut (
        .clk         (clk),
        .reset       (reset),
        .IMemData    (IMemData),
        .IALUOut     (IALUOut),
        .IPCPlus4    (IPCPlus4),
        .IWriteReg   (IWriteReg),
        .ICRegWrite  (ICRegWrite),
        .ICMemtoReg  (ICMemtoReg),
        .IReadReg1   (IReadReg1),
        .IReadReg2   (IReadReg2),
        .OReadData1  (OReadData1),
        .OReadData2  (OReadData2),
        .OWBData     (OWBData),
        .OWBValid    (OWBValid),
        .OWriteCount (OWriteCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared_cnt++;
        if (got !== exp) begin
            mismatch_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Inputs change 1ns after a rising edge; checks happen before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic we, input logic [4:0] idx, input logic [1:0] sel,
                               input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
        ICRegWrite = we;
        IWriteReg  = idx;
        ICMemtoReg = sel;
        IALUOut    = alu;
        IMemData   = mem;
        IPCPlus4   = pc;
    endtask

    task automatic read_pair(input logic [4:0] r1, input logic [4:0] r2);
        IReadReg1 = r1;
        IReadReg2 = r2;
        #1;
    endtask

    initial begin
        compared_cnt = 0;
        mismatch_cnt = 0;
        reset = 1'b1;
        drive_write(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
        IReadReg1 = 5'd29;
        IReadReg2 = 5'd5;
        tick();
        tick();

        // Reset state
        read_pair(5'd29, 5'd5);
        check("reset_sp",    OReadData1, 32'h0000_03FC);
        check("reset_r5",    OReadData2, 32'h0000_0000);
        check("reset_count", OWriteCount, 32'h0);
        reset = 1'b0;
        tick();

        // Load data writeback to r8
        drive_write(1'b1, 5'd8, 2'b01, 32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222);
        read_pair(5'd8, 5'd29);
        check("mem_valid",  {31'h0, OWBValid}, 32'h1);
        check("mem_wbdata", OWBData, 32'hDEAD_BEEF);
        check("mem_bypass", OReadData1, 32'hDEAD_BEEF);
        check("mem_other",  OReadData2, 32'h0000_03FC);
        tick();
        ICRegWrite = 1'b0;
        read_pair(5'd8, 5'd8);
        check("mem_stored", OReadData1, 32'hDEAD_BEEF);
        check("mem_count",  OWriteCount, 32'h1);

        // Same-cycle bypass on both ports
        drive_write(1'b1, 5'd9, 2'b00, 32'h0000_1234, 32'h0BAD_0BAD, 32'h0);
        read_pair(5'd9, 5'd9);
        check("byp_port1", OReadData1, 32'h0000_1234);
        check("byp_port2", OReadData2, 32'h0000_1234);
        tick();
        ICRegWrite = 1'b0;
        read_pair(5'd9, 5'd8);
        check("byp_stored", OReadData1, 32'h0000_1234);
        check("byp_r8",     OReadData2, 32'hDEAD_BEEF);
        check("byp_count",  OWriteCount, 32'h2);

        // Undefined select code 11 falls back to the ALU result
        drive_write(1'b1, 5'd10, 2'b11, 32'h0000_55AA, 32'hCAFE_F00D, 32'h0040_0000);
        read_pair(5'd10, 5'd0);
        check("sel11_wbdata", OWBData, 32'h0000_55AA);
        tick();
        ICRegWrite = 1'b0;
        read_pair(5'd10, 5'd0);
        check("sel11_stored", OReadData1, 32'h0000_55AA);
        check("sel11_count",  OWriteCount, 32'h3);

        // Write to $zero is discarded
        drive_write(1'b1, 5'd0, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'h0);
        read_pair(5'd0, 5'd0);
        check("zero_valid",  {31'h0, OWBValid}, 32'h0);
        check("zero_bypass", OReadData1, 32'h0);
        tick();
        ICRegWrite = 1'b0;
        read_pair(5'd0, 5'd0);
        check("zero_read",  OReadData2, 32'h0);
        check("zero_count", OWriteCount, 32'h3);

        // Write enable low leaves contents and counter alone
        drive_write(1'b0, 5'd8, 2'b00, 32'h7777_7777, 32'h0, 32'h0);
        read_pair(5'd8, 5'd0);
        check("nowe_valid", {31'h0, OWBValid}, 32'h0);
        check("nowe_read",  OReadData1, 32'hDEAD_BEEF);
        tick();
        read_pair(5'd8, 5'd0);
        check("nowe_stored", OReadData1, 32'hDEAD_BEEF);
        check("nowe_count",  OWriteCount, 32'h3);

        // Link address to r31
        drive_write(1'b1, 5'd31, 2'b10, 32'h0, 32'h0, 32'h0040_0010);
        read_pair(5'd31, 5'd9);
        check("link_wbdata", OWBData, 32'h0040_0010);
        tick();
        ICRegWrite = 1'b0;
        read_pair(5'd31, 5'd9);
        check("link_stored", OReadData1, 32'h0040_0010);
        check("link_count",  OWriteCount, 32'h4);

        // Reset wins over a simultaneous write; bypass off during reset
        drive_write(1'b1, 5'd31, 2'b10, 32'h0, 32'h0, 32'h0099_0000);
        reset = 1'b1;
        read_pair(5'd31, 5'd8);
        check("rstp_valid",  {31'h0, OWBValid}, 32'h0);
        check("rstp_nobyp",  OReadData1, 32'h0040_0010);
        check("rstp_array",  OReadData2, 32'hDEAD_BEEF);
        tick();
        reset = 1'b0;
        ICRegWrite = 1'b0;
        read_pair(5'd31, 5'd29);
        check("rstp_r31",   OReadData1, 32'h0);
        check("rstp_sp",    OReadData2, 32'h0000_03FC);
        check("rstp_count", OWriteCount, 32'h0);
        read_pair(5'd8, 5'd9);
        check("rstp_r8", OReadData1, 32'h0);
        check("rstp_r9", OReadData2, 32'h0);

        // Normal operation resumes from reset contents
        drive_write(1'b1, 5'd29, 2'b00, 32'h0000_0100, 32'h0, 32'h0);
        tick();
        ICRegWrite = 1'b0;
        read_pair(5'd29, 5'd31);
        check("resume_sp",    OReadData1, 32'h0000_0100);
        check("resume_count", OWriteCount, 32'h1);

        // Counter wraps from all-ones to zero
        force dut.write_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.write_count_reg;
        #1;
        check("wrap_preset", OWriteCount, 32'hFFFF_FFFF);
        drive_write(1'b1, 5'd3, 2'b01, 32'h0, 32'h0000_0007, 32'h0);
        tick();
        ICRegWrite = 1'b0;
        read_pair(5'd3, 5'd0);
        check("wrap_count", OWriteCount, 32'h0);
        check("wrap_r3",    OReadData1, 32'h0000_0007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have parameter SP_INIT, default 32'h0000_03FC, which is the reset value of register 29 ($sp).
REQ-002 The block SHALL have parameter LINK_ENC, default 2'b10, which is the ICMemtoReg code that selects IPCPlus4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 The block SHALL have port IMemData, input, 32 bits: load data from the MEM/WB register.
REQ-006 The block SHALL have port IALUOut, input, 32 bits: ALU result from the MEM/WB register.
REQ-007 The block SHALL have port IPCPlus4, input, 32 bits: link address from the MEM/WB register.
REQ-008 The block SHALL have port IWriteReg, input, 5 bits: destination register index.
REQ-009 The block SHALL have port ICRegWrite, input, 1 bit: write enable.
REQ-010 The block SHALL have port ICMemtoReg, input, 2 bits: writeback source select.
REQ-011 The block SHALL have ports IReadReg1 and IReadReg2, inputs, 5 bits each: ID-stage read indices.
REQ-012 The block SHALL have ports OReadData1 and OReadData2, outputs, 32 bits each: read data for the ID stage.
REQ-013 The block SHALL have port OWBData, output, 32 bits: selected writeback value, used for EX forwarding.
REQ-014 The block SHALL have port OWBValid, output, 1 bit: an effective write occurs at the next clock edge.
REQ-015 The block SHALL have port OWriteCount, output, 32 bits: count of retired effective writes.

Function
REQ-016 The block SHALL select OWBData combinationally: 2'b00 -> IALUOut, 2'b01 -> IMemData, LINK_ENC -> IPCPlus4, any other code -> IALUOut.
REQ-017 The block SHALL drive OWBValid = ICRegWrite AND (IWriteReg != 0) AND NOT reset.
REQ-018 The block SHALL, at each rising edge with OWBValid=1, write OWBData into register IWriteReg; the write latency is one edge.
REQ-019 The block SHALL keep register 0 reading as 32'h0 at all times; writes to index 0 SHALL be discarded.
REQ-020 The block SHALL make both read ports combinational (zero latency).
REQ-021 The block SHALL bypass write data: when OWBValid=1 and IReadRegN == IWriteReg, OReadDataN SHALL equal OWBData in the same cycle.
REQ-022 The block SHALL apply the bypass independently to both ports; both ports may hit the same index simultaneously.
REQ-023 The block SHALL increment OWriteCount by 1 at each edge where OWBValid=1, wrapping from 32'hFFFF_FFFF to 0.
REQ-024 The block SHALL leave contents and OWriteCount unchanged at an edge where ICRegWrite=0.

Reset
REQ-025 The block SHALL, at a rising edge with reset=1, clear registers 1-28 and 30-31 to 0, load register 29 with SP_INIT, and clear OWriteCount to 0.
REQ-026 Reset SHALL take priority over a simultaneous write; that write SHALL be lost and not counted.
REQ-027 The block SHALL disable the bypass while reset=1; read ports SHALL then return the stored array contents.
REQ-028 The block SHALL continue normal operation after reset deasserts mid-program, starting from the reset contents.

Structure
REQ-029 The MemtoReg encodings (ALU=2'b00, MEM=2'b01, LINK=2'b10) and the constants REG_ZERO=0 and REG_SP=29 SHALL reside in the shared pipeline package.
REQ-030 The writeback source mux SHALL be a combinational sub-module named wb_select; storage, bypass and counter SHALL stay in wb_regfile.

Verification
REQ-031 Reset scenario: assert reset, then read register 29 and register 5 -> 32'h0000_03FC and 0 respectively; OWriteCount = 0.
REQ-032 Writeback-select scenario: IWriteReg=8, ICRegWrite=1, ICMemtoReg=01, IMemData=32'hDEAD_BEEF, then clock -> register 8 reads 32'hDEAD_BEEF and OWriteCount = 1.
REQ-033 Bypass scenario: same-cycle write of IALUOut=32'h1234 to register 9 with IReadReg1=IReadReg2=9 -> both ports return 32'h1234 before the edge.
REQ-034 $zero scenario: write 32'hFFFF_FFFF to index 0 -> OWBValid=0, register 0 reads 0, and OWriteCount is unchanged.
REQ-035 Link and reset-priority scenario: ICMemtoReg=10 with IPCPlus4=32'h0040_0010 to register 31 -> register 31 holds 32'h0040_0010. Repeating the write with reset=1 -> register 31 = 0.
REQ-036 Counter wrap scenario: force OWriteCount to 32'hFFFF_FFFF, then perform one valid write -> OWriteCount = 0.
